ss_frame_sequencer: RTL and testbench

Parametrised successor to the single-strip ship sequencer in the WS2812B LED path. It debounces the Go button internally and ships GRB data to NUM_CH strips in turn, one channel per GRB engine pass. It then times the >280 us latch/reset period itself rather than waiting on an external allDone. Supports single-shot and continuous (auto-repeat) modes, with a stop request that is honoured only at frame boundaries.

---
 rtl/ss_pkg.sv | 20 ++
 rtl/ss_debounce.sv | 39 +++
 rtl/ss_frame_sequencer.sv | 125 ++++++++++++
 tb/tb_ss_frame_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared constants for the WS2812B frame sequencer: state encoding and
// default timing at a 100 MHz system clock.
package ss_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] SWAIT  = 3'd0;
  localparam logic [STATE_W-1:0] SSHIP  = 3'd1;
  localparam logic [STATE_W-1:0] SNEXT  = 3'd2;
  localparam logic [STATE_W-1:0] SLATCH = 3'd3;
  localparam logic [STATE_W-1:0] SGAP   = 3'd4;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_CHW             = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;  // 10 ms
  localparam int DEF_LATCH_CYCLES    = 30000;    // 300 us, above the 280 us reset
  localparam int DEF_GAP_CYCLES      = 1000000;  // 10 ms between frames
  localparam int DEF_CNTW            = 20;

endpackage

// File: rtl/ss_debounce.sv
// Go-button conditioner: 2-flop synchroniser followed by a saturating
// stable-high counter. Emits one go_evt pulse per press; the button must
// be released before another press can be recognised.
module ss_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,  // must be >= 2
  parameter int CNTW            = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic go_btn,
  output logic go_evt
);

  localparam logic [CNTW-1:0] LAST     = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNTW-1:0] PRE_LAST = CNTW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]      sync_q;
  logic [CNTW-1:0] cnt_q;
  logic            evt_q;

  // Synchronise, count stable-high clocks, pulse on the step into LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], go_btn};
      if (!sync_q[1])
        cnt_q <= '0;
      else if (cnt_q != LAST)
        cnt_q <= cnt_q + CNTW'(1);
      evt_q <= sync_q[1] && (cnt_q == PRE_LAST);
    end
  end

  assign go_evt = evt_q;

endmodule

// File: rtl/ss_frame_sequencer.sv
// Frame sequencer for NUM_CH WS2812B strips: ships each channel in turn
// through the GRB engine, times the line-low latch itself, and optionally
// auto-repeats with an idle gap. Stop is only honoured at frame boundaries.
module ss_frame_sequencer
  import ss_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int CHW             = DEF_CHW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LATCH_CYCLES    = DEF_LATCH_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int CNTW            = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go_btn,
  input  logic            continuous,
  input  logic            stop,
  input  logic            done,
  output logic            ship_grb,
  output logic [CHW-1:0]  ch_idx,
  output logic            latch_active,
  output logic            ready2go,
  output logic            frame_done,
  output logic [15:0]     frame_count
);

  localparam logic [CHW-1:0]  LAST_CH   = CHW'(NUM_CH - 1);
  localparam logic [CNTW-1:0] LATCH_END = CNTW'(LATCH_CYCLES - 1);
  localparam logic [CNTW-1:0] GAP_END   = CNTW'(GAP_CYCLES - 1);

  logic                go_evt;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q;

  ss_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNTW            (CNTW)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .go_btn (go_btn),
    .go_evt (go_evt)
  );

  // Next-state logic; the latch and gap timers share cnt_q.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      SWAIT: begin
        if (go_evt) begin
          state_d = SSHIP;
          ch_d    = '0;
        end
      end
      SSHIP: begin
        if (done) state_d = SNEXT;
      end
      SNEXT: begin
        // One ship_grb-low clock between channels.
        if (ch_q == LAST_CH) begin
          state_d = SLATCH;
          cnt_d   = '0;
        end else begin
          state_d = SSHIP;
          ch_d    = ch_q + CHW'(1);
        end
      end
      SLATCH: begin
        if (cnt_q == LATCH_END) begin
          frame_done_d = 1'b1;
          ch_d         = '0;
          cnt_d        = '0;
          state_d      = (continuous && !stop) ? SGAP : SWAIT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      SGAP: begin
        if (stop || !continuous) begin
          state_d = SWAIT;
          cnt_d   = '0;
        end else if (cnt_q == GAP_END) begin
          state_d = SSHIP;
          ch_d    = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = SWAIT;
    endcase
  end

  // State, channel, timer and frame bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SWAIT;
      ch_q          <= '0;
      cnt_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      if (frame_done_d) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign ship_grb     = (state_q == SSHIP);
  assign latch_active = (state_q == SLATCH);
  assign ready2go     = (state_q == SWAIT);
  assign ch_idx       = ch_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_ss_frame_sequencer.sv
// Directed-plus-random bench for ss_frame_sequencer with small timing
// parameters. Expected behaviour comes from a frame-level model: a frame
// is NUM_CH channel passes, each ended by one done, with a one-clock gap,
// followed by LATCH clocks of latch and one frame_done pulse.
module tb_ss_frame_sequencer;

  localparam int NUM_CH = 3;
  localparam int CHW    = 2;
  localparam int DEB    = 8;
  localparam int LATCH  = 16;
  localparam int GAP    = 8;
  localparam int CNTW   = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic go_btn = 1'b0, continuous = 1'b0, stop = 1'b0, done = 1'b0;
  logic ship_grb, latch_active, ready2go, frame_done;
  logic [CHW-1:0] ch_idx;
  logic [15:0]    frame_count;

  int passed = 0, fails = 0, total = 0;
  logic [15:0] model_fc = '0;

  always #5 clk = ~clk;

  ss_frame_sequencer #(
    .NUM_CH(NUM_CH), .CHW(CHW), .DEBOUNCE_CYCLES(DEB),
    .LATCH_CYCLES(LATCH), .GAP_CYCLES(GAP), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .go_btn(go_btn), .continuous(continuous),
    .stop(stop), .done(done), .ship_grb(ship_grb), .ch_idx(ch_idx),
    .latch_active(latch_active), .ready2go(ready2go),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ship(input string tag);
    int k = 0;
    while (ship_grb !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(tag, ship_grb, 1);
  endtask

  // Watch a window for any ship_grb activity (should stay idle).
  task automatic idle_window(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (ship_grb) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  // Drive one frame from the first ship_grb rise; ends on the negedge where
  // frame_done is visible. rst_at>0 aborts with reset on that latch clock.
  task automatic run_frame(input bit stop_mid, input bit press_mid,
                           input bit spurious, input int rst_at);
    int lat, n, k;
    for (int c = 0; c < NUM_CH; c++) begin
      wait_ship("ship_rise");
      check("ch_idx", ch_idx, c);
      lat = $urandom_range(12, 1);
      if (c == 1 && stop_mid) stop = 1'b1;
      if (c == 1 && press_mid) begin
        go_btn = 1'b1;
        lat = 14;
      end
      repeat (lat - 1) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      if (c == 0 || press_mid) go_btn = 1'b0;
      check("inter_ch_gap", ship_grb, 0);
    end
    k = 0;
    while (latch_active !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    check("latch_start", latch_active, 1);
    n = 0;
    while (latch_active === 1'b1 && n < 100) begin
      n++;
      done = spurious && (n == 5);
      if (rst_at != 0 && n == rst_at) begin
        done = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_ship", ship_grb, 0);
        check("rst_latch", latch_active, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_fcount", frame_count, 0);
        check("rst_ch", ch_idx, 0);
        return;
      end
      @(negedge clk);
    end
    done = 1'b0;
    check("latch_len", n, LATCH);
    model_fc = model_fc + 16'd1;
    check("frame_done", frame_done, 1);
    check("frame_count", frame_count, model_fc);
    check("ch_idx_end", ch_idx, 0);
  endtask

  initial begin
    int g;
    // Reset state
    #3;
    check("reset_ship", ship_grb, 0);
    check("reset_latch", latch_active, 0);
    check("reset_fdone", frame_done, 0);
    check("reset_fcount", frame_count, 0);
    check("reset_ch", ch_idx, 0);
    check("reset_ready", ready2go, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Short press does not count
    go_btn = 1'b1;
    repeat (5) @(negedge clk);
    go_btn = 1'b0;
    idle_window("short_press", 20);
    check("short_ready", ready2go, 1);

    // Spurious done while waiting
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    idle_window("done_in_wait", 3);
    check("done_wait_ready", ready2go, 1);

    // Single-shot frames with random done latency
    for (int f = 0; f < 2; f++) begin
      go_btn = 1'b1;
      run_frame(1'b0, 1'b0, 1'b0, 0);
      check("single_ready", ready2go, 1);
      @(negedge clk);
      check("fdone_pulse", frame_done, 0);
      idle_window("single_no_repeat", 25);
    end

    // Second press mid-frame and done during latch are ignored
    go_btn = 1'b1;
    run_frame(1'b0, 1'b1, 1'b1, 0);
    check("spur_ready", ready2go, 1);
    idle_window("spur_no_extra", 30);

    // Continuous: frame 1, gap, frame 2 with stop, then idle
    continuous = 1'b1;
    go_btn = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 0);
    check("cont_not_ready", ready2go, 0);
    @(negedge clk);
    check("cont_fdone_low", frame_done, 0);
    g = 2;
    while (ship_grb !== 1'b1 && g < 50) begin
      @(negedge clk);
      if (ship_grb !== 1'b1) g++;
    end
    check("gap_len", g, GAP);
    run_frame(1'b1, 1'b0, 1'b0, 0);
    check("stop_ready", ready2go, 1);
    idle_window("stop_no_third", 40);
    stop = 1'b0;
    continuous = 1'b0;

    // Asynchronous reset in the middle of the latch
    go_btn = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 5);
    go_btn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_fc = '0;
    @(negedge clk);
    check("post_rst_ready", ready2go, 1);
    check("post_rst_fcount", frame_count, 0);

    // Frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    model_fc = 16'hFFFF;
    check("preload", frame_count, 16'hFFFF);
    go_btn = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 0);
    check("wrap_zero", frame_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "timeout");
  end

endmodule
